apb_regfile_completer: RTL and testbench
========================================

Name: apb_regfile_completer

Overview:
APB4 completer (slave) terminating the PSEL/PENABLE/PREADY handshake driven by the AHB-Lite-to-APB bridge. It holds a bank of 32-bit registers and supports byte-strobed writes, programmable wait states, error responses and a sticky protocol-violation flag. Register contents are exported flat so downstream logic can use them. It also serves as the bridge's default verification target.

Parameters:
NUM_REGS, 16, number of 32-bit registers; offset 0x0 is a read-only ID register.
ADDR_W, 12, PADDR LSBs decoded locally; upper bits are ignored because the bridge already gates PSEL.
WAIT_STATES, 2, PREADY-low cycles inserted in the access phase (0..15).
ID_VALUE, 32'hA5B0_0001, value returned by register 0.
PRIV_MASK, 16'h0002, bit i set means register i accepts writes only when PROT[0]=1 (privileged).

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  completer select
PENABLE  in  1  access-phase indicator
PROT  in  3  protection; only bit 0 (privileged) is used
PWRITE  in  1  1=write, 0=read
PSTRB  in  4  write byte strobes
PADDR  in  32  address
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  error response, valid only when PREADY=1
reg_q  out  NUM_REGS*32  flattened register contents, reg i at [32i+31:32i]
proto_err  out  1  sticky APB protocol-violation flag

Behaviour:
- Clock and reset: one clock, PCLK. PRESETn is asynchronous and active-low. During reset all registers are 0, FSM=IDLE, wait counter=0 and proto_err=0. While PRESETn=0, PRDATA, PREADY and PSLVERR are 0.
- FSM states are IDLE and ACCESS.
  - IDLE: on PSEL=1 & PENABLE=0 (setup phase), capture PADDR/PWRITE/PSTRB/PWDATA/PROT, load wcnt=WAIT_STATES, next state ACCESS.
  - IDLE: on PSEL=1 & PENABLE=1 (access without setup), set proto_err, remain IDLE, PREADY=0.
  - ACCESS: if PSEL=0, abort to IDLE; no write occurs and proto_err is set.
  - ACCESS: if PSEL=1 & wcnt>0, decrement wcnt; PREADY=0.
  - ACCESS: if PSEL=1 & PENABLE=1 & wcnt=0, then PREADY=1 (combinational) and next state is IDLE.
- Latency: each transfer takes 2+WAIT_STATES cycles from setup to completion.
- Back-to-back transfers: a new setup phase in the cycle after completion is accepted with no idle gap.
- Captured-signal change during ACCESS: any change of PADDR/PWRITE/PWDATA/PSTRB versus the captured copy sets proto_err. The captured copy is used for the transfer.
- Error decode, evaluated on the captured offset; PSLVERR=1 when any of the following holds:
  - offset[1:0]!=0 (unaligned);
  - offset >= NUM_REGS*4 (out of range);
  - write to register 0 (read-only ID);
  - write to a register with its PRIV_MASK bit set while PROT[0]=0.
- On error: no register changes, and PRDATA=0 for an errored read.
- Write commit: at the completion edge (PREADY=1, no error), bytes with PSTRB[b]=1 are updated. PSTRB=0 is a legal no-op write.
- Read data: PRDATA = register value when PREADY=1 & !PWRITE & no error, otherwise 0. Read-side PSTRB is ignored.
- PSLVERR is 0 whenever PREADY=0.
- proto_err clears only on reset.
- Reset mid-transfer: the FSM returns to IDLE immediately and any pending write is discarded.

Decomposition:
- Package apb_regfile_pkg holds:
  - the state enum typedef (IDLE, ACCESS);
  - a typedef for the captured transfer struct (addr, write, strb, wdata, prot);
  - the ID_OFFSET and byte-lane constants;
  - an error-cause enum (UNALIGNED, RANGE, RO, PRIV) for debug.
- Sub-module apb_reg_bank holds the NUM_REGS×32 storage: byte-strobed write port, combinational read port, read-only ID at index 0.
- The top level holds the FSM, wait counter, error decode and protocol checker.

Test Plan:
1. Assert PRESETn=0 for 3 cycles mid-stream -> PREADY=0, PSLVERR=0, PRDATA=0, reg_q all 0, proto_err=0.
2. With WAIT_STATES=2, write 0xDEADBEEF to 0x008 with PSTRB=4'hF -> PREADY low for 2 access cycles, high on the 3rd, PSLVERR=0; read 0x008 -> PRDATA=0xDEADBEEF; reg_q[95:64]=0xDEADBEEF.
3. Write 0x11223344 with PSTRB=4'b0101 to 0x008 -> read 0xDE22BE44. Then write with PSTRB=0 -> value unchanged.
4. Error cases, all with PREADY=1 and no state change:
   - write 0x0 -> PSLVERR=1 and read 0x0 returns 0xA5B00001;
   - access 0x040 -> PSLVERR=1;
   - access 0x005 -> PSLVERR=1;
   - write 0x004 with PROT=3'b000 -> PSLVERR=1, while the same write with PROT=3'b001 succeeds.
5. Protocol violations:
   - drop PSEL during a wait state -> abort, register unchanged, proto_err=1;
   - PENABLE=1 with no setup phase -> proto_err=1, PREADY stays 0;
   - change PWDATA mid-access -> proto_err=1.
6. With WAIT_STATES=0, run back-to-back write 0x00C, read 0x00C, write 0x010 -> each completes in 2 cycles, PREADY high in every access cycle, read returns the data just written.

Source files
------------

// File: rtl/apb_regfile_pkg.sv
// Shared types and constants for the APB register-file completer.
// Contents:
//   apb_state_e  - completer FSM states (IDLE, ACCESS)
//   apb_xfer_t   - transfer fields captured in the setup phase
//   ID_OFFSET    - byte offset of the read-only ID register
//   BYTE_LANES   - number of byte lanes in a 32-bit word (one PSTRB bit each)
//   BYTE_W       - width of one byte lane
//   err_cause_e  - reason a transfer was answered with PSLVERR (debug aid)
package apb_regfile_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [2:0]  prot;
  } apb_xfer_t;

  localparam int ID_OFFSET  = 0;
  localparam int BYTE_LANES = 4;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    UNALIGNED  = 3'd1,
    RANGE      = 3'd2,
    RO         = 3'd3,
    PRIV       = 3'd4
  } err_cause_e;

endpackage

// File: rtl/apb_reg_bank.sv
// Storage for the completer's 32-bit registers.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset (clears all storage)
//   we         - commit a write this cycle
//   widx       - register index being written
//   wstrb      - byte-lane enables for the write
//   wdata      - write data
//   ridx       - register index being read
//   rdata      - combinational read data; the ID index returns ID_VALUE
//   regs_flat  - all storage flattened, register i at [32i+31:32i]
module apb_reg_bank
  import apb_regfile_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter int          IDX_W    = 4,
  parameter logic [31:0] ID_VALUE = 32'hA5B0_0001
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [BYTE_LANES-1:0]   wstrb,
  input  logic [31:0]             wdata,
  input  logic [IDX_W-1:0]        ridx,
  output logic [31:0]             rdata,
  output logic [NUM_REGS*32-1:0]  regs_flat
);

  localparam logic [IDX_W-1:0] ID_IDX = IDX_W'(ID_OFFSET / BYTE_LANES);

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  // Byte-lane merge. The ID slot is never written, so its storage stays at
  // zero and the ID value only appears on the read port.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we && (widx != ID_IDX)) begin
      for (int b = 0; b < BYTE_LANES; b++) begin
        if (wstrb[b]) begin
          regs_d[widx][BYTE_W*b +: BYTE_W] = wdata[BYTE_W*b +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rdata = (ridx == ID_IDX) ? ID_VALUE : regs_q[ridx];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[32*g +: 32] = regs_q[g];
  end

endmodule

// File: rtl/apb_regfile_completer.sv
// APB4 completer fronting a bank of 32-bit registers.
// Ports:
//   PCLK, PRESETn - clock and asynchronous active-low reset
//   PSEL, PENABLE - APB select / access-phase handshake from the bridge
//   PROT          - protection; bit 0 marks a privileged access
//   PWRITE, PSTRB, PADDR, PWDATA - transfer request
//   PRDATA        - read data, zero unless a successful read completes
//   PREADY        - transfer completes this cycle
//   PSLVERR       - error response, only ever high together with PREADY
//   reg_q         - flattened register storage, register i at [32i+31:32i]
//   proto_err     - sticky flag for APB handshake / stability violations
module apb_regfile_completer
  import apb_regfile_pkg::*;
#(
  parameter int                  NUM_REGS    = 16,
  parameter int                  ADDR_W      = 12,
  parameter int                  WAIT_STATES = 2,
  parameter logic [31:0]         ID_VALUE    = 32'hA5B0_0001,
  parameter logic [NUM_REGS-1:0] PRIV_MASK   = 16'h0002
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic [2:0]             PROT,
  input  logic                   PWRITE,
  input  logic [3:0]             PSTRB,
  input  logic [31:0]            PADDR,
  input  logic [31:0]            PWDATA,
  output logic [31:0]            PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic [NUM_REGS*32-1:0] reg_q,
  output logic                   proto_err
);

  localparam int                IDX_W     = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] RANGE_END = ADDR_W'(NUM_REGS * BYTE_LANES);
  localparam logic [IDX_W-1:0]  ID_IDX    = IDX_W'(ID_OFFSET / BYTE_LANES);
  localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_STATES);

  apb_state_e  state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  apb_xfer_t   xfer_q, xfer_d;
  logic        proto_err_q, proto_err_d;

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  reg_idx;
  err_cause_e        err_cause;
  logic              xfer_err;
  logic              bus_changed;
  logic              pready;
  logic              bank_we;
  logic [31:0]       bank_rdata;
  logic              unused_prot;

  // Only the low ADDR_W bits are decoded; the bridge has already qualified
  // PSEL with the upper address bits.
  assign offset      = xfer_q.addr[ADDR_W-1:0];
  assign reg_idx     = offset[2 +: IDX_W];
  assign unused_prot = ^xfer_q.prot[2:1];

  // Error decode on the captured copy, first matching cause wins.
  always_comb begin
    err_cause = CAUSE_NONE;
    if (offset[1:0] != 2'b00) begin
      err_cause = UNALIGNED;
    end else if (offset >= RANGE_END) begin
      err_cause = RANGE;
    end else if (xfer_q.write && (reg_idx == ID_IDX)) begin
      err_cause = RO;
    end else if (xfer_q.write && PRIV_MASK[reg_idx] && !xfer_q.prot[0]) begin
      err_cause = PRIV;
    end
  end

  assign xfer_err = (err_cause != CAUSE_NONE);

  // The requester must hold the transfer stable until PREADY; compare the
  // live bus against what was captured in the setup phase.
  assign bus_changed = (PADDR  != xfer_q.addr)  ||
                       (PWRITE != xfer_q.write) ||
                       (PSTRB  != xfer_q.strb)  ||
                       (PWDATA != xfer_q.wdata);

  assign pready = (state_q == ACCESS) && PSEL && PENABLE && (wcnt_q == 4'd0);

  // Next-state logic: setup capture, wait-state countdown, completion,
  // abort, and protocol-violation tracking.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    xfer_d      = xfer_q;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if (PSEL) begin
          if (!PENABLE) begin
            xfer_d.addr  = PADDR;
            xfer_d.write = PWRITE;
            xfer_d.strb  = PSTRB;
            xfer_d.wdata = PWDATA;
            xfer_d.prot  = PROT;
            wcnt_d       = WAIT_LOAD;
            state_d      = ACCESS;
          end else begin
            proto_err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d     = IDLE;
          proto_err_d = 1'b1;
        end else begin
          if (bus_changed || !PENABLE) begin
            proto_err_d = 1'b1;
          end
          if (wcnt_q != 4'd0) begin
            wcnt_d = wcnt_q - 4'd1;
          end else if (PENABLE) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // Aborting or resetting mid-transfer leaves no pending write behind because
  // the bank only commits on the completion cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      xfer_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      xfer_q      <= xfer_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bank_we = pready && xfer_q.write && !xfer_err;

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .we        (bank_we),
    .widx      (reg_idx),
    .wstrb     (xfer_q.strb),
    .wdata     (xfer_q.wdata),
    .ridx      (reg_idx),
    .rdata     (bank_rdata),
    .regs_flat (reg_q)
  );

  assign PREADY    = pready;
  assign PSLVERR   = pready && xfer_err;
  assign PRDATA    = (pready && !xfer_q.write && !xfer_err) ? bank_rdata : 32'h0;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Scoreboard bench for apb_regfile_completer: dut0 runs with two wait states,
// dut1 with none. Both share the bus except PSEL, so only one is addressed
// at a time. Expected responses come from an array model of the registers.
module tb_apb_regfile_completer;

  localparam int          NREG   = 16;
  localparam logic [31:0] ID_VAL = 32'hA5B0_0001;
  localparam logic [15:0] PMASK  = 16'h0002;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [1:0]        psel;
  logic              penable;
  logic              pwrite;
  logic [2:0]        prot;
  logic [3:0]        pstrb;
  logic [31:0]       paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata [2];
  logic [1:0]        pready;
  logic [1:0]        pslverr;
  logic [1:0]        proto_err;
  logic [NREG*32-1:0] regq [2];

  typedef struct {
    int          dut;
    int          tag;
    logic [31:0] rdata;
    logic        slverr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model [2][NREG];
  int          total = 0;
  int          bad = 0;
  int          tag_n = 0;

  always #5 PCLK = ~PCLK;

  apb_regfile_completer #(.WAIT_STATES(2)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable),
    .PROT(prot), .PWRITE(pwrite), .PSTRB(pstrb), .PADDR(paddr),
    .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .reg_q(regq[0]), .proto_err(proto_err[0])
  );

  apb_regfile_completer #(.WAIT_STATES(0)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable),
    .PROT(prot), .PWRITE(pwrite), .PSTRB(pstrb), .PADDR(paddr),
    .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .reg_q(regq[1]), .proto_err(proto_err[1])
  );

  function automatic int wsOf(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Reference error rules, straight from the register map.
  function automatic logic expErr(input logic [31:0] a, input logic wr, input logic [2:0] pr);
    int off;
    int idx;
    off = int'(a[11:0]);
    idx = off / 4;
    if ((off % 4) != 0) return 1'b1;
    if (off >= NREG * 4) return 1'b1;
    if (wr && idx == 0) return 1'b1;
    if (wr && PMASK[idx] && !pr[0]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clearModel();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NREG; i++) begin
        model[d][i] = 32'h0;
      end
    end
  endtask

  task automatic checkRegs(input int d);
    for (int i = 1; i < NREG; i++) begin
      checkOutput($sformatf("reg_q[%0d] dut%0d", i, d), regq[d][32*i +: 32], model[d][i]);
    end
  endtask

  task automatic idleBus();
    psel    = 2'b00;
    penable = 1'b0;
    @(posedge PCLK);
    #1;
  endtask

  task automatic pulseReset();
    PRESETn = 1'b0;
    psel    = 2'b00;
    penable = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    clearModel();
    @(posedge PCLK);
    #1;
  endtask

  // One full APB transfer; the expected response is queued before the bus
  // is driven and the monitor compares it when PREADY appears.
  task automatic applyStimulus(input int d, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] st,
                               input logic [2:0] pr, input bit glitch);
    exp_t e;
    int   idx;
    int   cycles;
    bit   done;
    idx      = int'(a[11:0]) / 4;
    e.dut    = d;
    e.tag    = tag_n;
    tag_n++;
    e.slverr = expErr(a, wr, pr);
    e.rdata  = 32'h0;
    if (!e.slverr) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (st[b]) model[d][idx][8*b +: 8] = wd[8*b +: 8];
        end
      end else begin
        e.rdata = (idx == 0) ? ID_VAL : model[d][idx];
      end
    end
    exp_q.push_back(e);

    psel    = 2'b00;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    pstrb   = st;
    prot    = pr;
    @(posedge PCLK);
    #1;
    penable = 1'b1;
    if (glitch) pwdata = ~wd;
    cycles = 1;
    done   = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge PCLK);
      cycles++;
      if (pready[d]) done = 1'b1;
      @(posedge PCLK);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout dut%0d xfer%0d: actual=no PREADY required=PREADY", d, e.tag);
    end else begin
      checkOutput($sformatf("latency dut%0d xfer%0d", d, e.tag), 32'(cycles), 32'(2 + wsOf(d)));
    end
  endtask

  task automatic randomXfers(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      int          sel;
      logic [11:0] off;
      sel = $urandom_range(0, 9);
      if (sel <= 6)      off = 12'($urandom_range(0, 15) * 4);
      else if (sel == 7) off = 12'($urandom_range(16, 1023) * 4);
      else if (sel == 8) off = 12'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else               off = 12'h000;
      applyStimulus(d, 1'($urandom_range(0, 1)),
                    ($urandom() & 32'hFFFF_F000) | {20'h0, off},
                    $urandom(), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 1'b0);
    end
  endtask

  // Monitor: pops an expectation whenever a DUT completes a transfer and
  // checks that outputs stay quiet otherwise.
  initial begin
    forever begin
      @(negedge PCLK);
      if (PRESETn) begin
        for (int d = 0; d < 2; d++) begin
          if (pready[d]) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("[TB] FAIL unexpected_pready dut%0d: actual=1 required=0", d);
            end else begin
              mon_e = exp_q.pop_front();
              checkOutput($sformatf("xfer%0d dut", mon_e.tag), 32'(d), 32'(mon_e.dut));
              checkOutput($sformatf("xfer%0d PRDATA", mon_e.tag), prdata[d], mon_e.rdata);
              checkOutput($sformatf("xfer%0d PSLVERR", mon_e.tag), 32'(pslverr[d]), 32'(mon_e.slverr));
            end
          end else begin
            checkOutput($sformatf("quiet dut%0d", d), {prdata[d][31:1], prdata[d][0] | pslverr[d]}, 32'h0);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    psel = 2'b00; penable = 1'b0; pwrite = 1'b0; prot = 3'b000;
    pstrb = 4'h0; paddr = 32'h0; pwdata = 32'h0;
    clearModel();
    $display("[TB] reset and initial state");
    repeat (3) @(posedge PCLK);
    #1;
    checkOutput("reset PREADY", 32'(pready[0]), 32'h0);
    checkOutput("reset PSLVERR", 32'(pslverr[0]), 32'h0);
    checkOutput("reset PRDATA", prdata[0], 32'h0);
    checkOutput("reset proto_err", 32'(proto_err[0]), 32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;

    $display("[TB] basic write/read with wait states");
    applyStimulus(0, 1'b1, 32'h008, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0);
    applyStimulus(0, 1'b0, 32'h008, 32'h0, 4'h0, 3'b000, 1'b0);
    idleBus();
    checkOutput("reg2 full write", regq[0][95:64], 32'hDEADBEEF);

    $display("[TB] byte strobes");
    applyStimulus(0, 1'b1, 32'h008, 32'h11223344, 4'b0101, 3'b000, 1'b0);
    applyStimulus(0, 1'b0, 32'h008, 32'h0, 4'hF, 3'b000, 1'b0);
    idleBus();
    checkOutput("reg2 strobed", regq[0][95:64], 32'hDE22BE44);
    applyStimulus(0, 1'b1, 32'h008, 32'hFFFFFFFF, 4'b0000, 3'b000, 1'b0);
    applyStimulus(0, 1'b0, 32'h008, 32'h0, 4'h0, 3'b000, 1'b0);
    idleBus();
    checkOutput("reg2 zero strobe", regq[0][95:64], 32'hDE22BE44);

    $display("[TB] error responses");
    applyStimulus(0, 1'b1, 32'h000, 32'h12345678, 4'hF, 3'b001, 1'b0);
    applyStimulus(0, 1'b0, 32'h000, 32'h0, 4'h0, 3'b000, 1'b0);
    applyStimulus(0, 1'b0, 32'h040, 32'h0, 4'h0, 3'b000, 1'b0);
    applyStimulus(0, 1'b1, 32'h040, 32'h55AA55AA, 4'hF, 3'b001, 1'b0);
    applyStimulus(0, 1'b0, 32'h005, 32'h0, 4'h0, 3'b000, 1'b0);
    applyStimulus(0, 1'b1, 32'h004, 32'hCAFEF00D, 4'hF, 3'b000, 1'b0);
    applyStimulus(0, 1'b0, 32'h004, 32'h0, 4'h0, 3'b000, 1'b0);
    applyStimulus(0, 1'b1, 32'h004, 32'hCAFEF00D, 4'hF, 3'b001, 1'b0);
    applyStimulus(0, 1'b0, 32'h004, 32'h0, 4'h0, 3'b000, 1'b0);
    idleBus();
    checkOutput("reg1 privileged write", regq[0][63:32], 32'hCAFEF00D);
    checkRegs(0);
    checkOutput("proto_err clean dut0", 32'(proto_err[0]), 32'h0);

    $display("[TB] random traffic dut0");
    randomXfers(0, 60);
    idleBus();
    checkRegs(0);
    checkOutput("proto_err after random dut0", 32'(proto_err[0]), 32'h0);

    $display("[TB] abort in wait state");
    psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 32'h008;
    pwdata = 32'h0BADF00D; pstrb = 4'hF; prot = 3'b001;
    @(posedge PCLK);
    #1;
    penable = 1'b1;
    @(posedge PCLK);
    #1;
    idleBus();
    idleBus();
    checkRegs(0);
    checkOutput("proto_err after abort", 32'(proto_err[0]), 32'h1);

    $display("[TB] reset mid-transfer");
    psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 32'h014;
    pwdata = 32'h7777_1111; pstrb = 4'hF; prot = 3'b001;
    @(posedge PCLK);
    #1;
    penable = 1'b1;
    @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    #1;
    checkOutput("midreset PREADY", 32'(pready[0]), 32'h0);
    checkOutput("midreset PSLVERR", 32'(pslverr[0]), 32'h0);
    checkOutput("midreset PRDATA", prdata[0], 32'h0);
    checkOutput("midreset proto_err", 32'(proto_err[0]), 32'h0);
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("midreset PREADY held", 32'(pready[0]), 32'h0);
    for (int i = 0; i < NREG; i++) begin
      checkOutput($sformatf("midreset reg_q[%0d]", i), regq[0][32*i +: 32], 32'h0);
    end
    psel = 2'b00;
    penable = 1'b0;
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    clearModel();
    idleBus();
    checkRegs(0);

    $display("[TB] access phase without setup");
    psel = 2'b01; penable = 1'b1; pwrite = 1'b1; paddr = 32'h008;
    pwdata = 32'h1234_5678; pstrb = 4'hF; prot = 3'b001;
    @(negedge PCLK);
    checkOutput("nosetup PREADY", 32'(pready[0]), 32'h0);
    @(posedge PCLK);
    #1;
    idleBus();
    checkOutput("proto_err after nosetup", 32'(proto_err[0]), 32'h1);
    checkRegs(0);
    pulseReset();

    $display("[TB] write data changed mid-access");
    applyStimulus(0, 1'b1, 32'h010, 32'h600DCAFE, 4'hF, 3'b000, 1'b1);
    applyStimulus(0, 1'b0, 32'h010, 32'h0, 4'h0, 3'b000, 1'b0);
    idleBus();
    checkOutput("proto_err after glitch", 32'(proto_err[0]), 32'h1);
    checkOutput("reg4 captured data", regq[0][159:128], 32'h600DCAFE);
    pulseReset();

    $display("[TB] back-to-back without wait states");
    applyStimulus(1, 1'b1, 32'h00C, 32'h13579BDF, 4'hF, 3'b000, 1'b0);
    applyStimulus(1, 1'b0, 32'h00C, 32'h0, 4'h0, 3'b000, 1'b0);
    applyStimulus(1, 1'b1, 32'h010, 32'h2468ACE0, 4'hF, 3'b000, 1'b0);
    applyStimulus(1, 1'b0, 32'h010, 32'h0, 4'h0, 3'b000, 1'b0);
    randomXfers(1, 40);
    idleBus();
    checkRegs(1);
    checkOutput("proto_err dut1", 32'(proto_err[1]), 32'h0);

    repeat (3) @(posedge PCLK);
    #1;
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
